// File: rtl/uart_tx_engine.sv
// UART transmitter: frames one DBIT-wide word per request (start, data LSB first,
// optional parity, stop) with bit timing driven by a 16x oversampling tick.
module uart_tx_engine #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int unsigned TW = 5;
    localparam int unsigned BW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick;
    logic [BW-1:0]   r_bit;
    logic [DBIT-1:0] r_shift;
    logic            r_par;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nxt;
    logic [TW-1:0]   w_tick_nxt;
    logic [BW-1:0]   w_bit_nxt;
    logic [DBIT-1:0] w_shift_nxt;
    logic            w_par_nxt;
    logic            w_tx_nxt;
    logic            w_done_nxt;

    // State and datapath registers; outputs are registered from next-state values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; every state clears the tick counter on exit
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_shift_nxt = tx_din;
                    w_par_nxt   = ^tx_din;
                    w_tick_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (r_tick == TW'(15)) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (r_tick == TW'(15)) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = r_shift >> 1;
                        if (r_bit == BW'(DBIT - 1)) begin
                            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_nxt = r_bit + BW'(1);
                        end
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (s_tick) begin
                    if (r_tick == TW'(15)) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
            end
            S_STOP: begin
                if (s_tick) begin
                    if (r_tick == TW'(SB_TICK - 1)) begin
                        w_tick_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
            end
            default: begin
                w_tick_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level for the state being entered
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_par_nxt ^ 1'(PARITY == 2);
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;

endmodule
